wave_capture: RTL

Write-side counterpart of the wave display path. Accepts a stream of signed audio samples and detects a positive-going zero crossing. It then writes 256 consecutive 8-bit offset-binary samples into one half of the 512-entry sample RAM. After that it waits for the display to go idle and swaps halves by toggling `read_index`. The display always reads half `read_index`; this block always writes half `~read_index`.

---
 rtl/wave_capture.sv | 63 ++++++
 1 files changed

// File: rtl/wave_capture.sv
// wave_capture: triggers on a positive zero crossing, writes 256 offset-binary samples to the back half, then swaps halves when the display is idle
module wave_capture #(
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    new_sample_ready,
   input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
   input  logic                    wave_display_idle,
   output logic [8:0]              write_address,
   output logic                    write_enable,
   output logic [7:0]              write_sample,
   output logic                    read_index
);
   typedef enum logic [1:0] {ST_ARMED, ST_ACTIVE, ST_WAIT} state_t;
   state_t      state_q, state_d;
   logic [7:0]  count_q, count_d;
   logic        prev_msb_q, prev_msb_d;
   logic        read_index_q, read_index_d;
   logic        write_enable_q, write_enable_d;
   logic [8:0]  write_address_q, write_address_d;
   logic [7:0]  write_sample_q, write_sample_d;
   logic        msb, crossing, accept;
   // next-state: trigger detect, capture counting, write register staging, and half swap
   always_comb begin
      msb             = new_sample_in[SAMPLE_WIDTH-1];
      crossing        = new_sample_ready && prev_msb_q && !msb;
      accept          = (state_q == ST_ARMED && crossing) || (state_q == ST_ACTIVE && new_sample_ready);
      state_d         = state_q == ST_ARMED  ? (crossing ? ST_ACTIVE : ST_ARMED) :
                        state_q == ST_ACTIVE ? ((accept && count_q == 8'hFF) ? ST_WAIT : ST_ACTIVE) :
                        (wave_display_idle ? ST_ARMED : ST_WAIT);
      count_d         = accept ? count_q + 8'd1 : count_q;
      prev_msb_d      = new_sample_ready ? msb : prev_msb_q;
      read_index_d    = (state_q == ST_WAIT && wave_display_idle) ? ~read_index_q : read_index_q;
      write_enable_d  = accept;
      write_address_d = accept ? {~read_index_q, count_q} : write_address_q;
      write_sample_d  = accept ? {~msb, new_sample_in[SAMPLE_WIDTH-2 -: 7]} : write_sample_q;
   end
   // state registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= ST_ARMED;
         count_q         <= '0;
         prev_msb_q      <= 1'b0;
         read_index_q    <= 1'b0;
         write_enable_q  <= 1'b0;
         write_address_q <= '0;
         write_sample_q  <= '0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         prev_msb_q      <= prev_msb_d;
         read_index_q    <= read_index_d;
         write_enable_q  <= write_enable_d;
         write_address_q <= write_address_d;
         write_sample_q  <= write_sample_d;
      end
   end
   assign write_enable  = write_enable_q;
   assign write_address = write_address_q;
   assign write_sample  = write_sample_q;
   assign read_index    = read_index_q;
endmodule
